instruction_encoder: RTL and testbench

Assembles typed instruction fields into 18-bit raw instruction words. Streams those words into control-unit instruction memory. It is the encoding counterpart of the control-unit decoder, so every word it writes decodes back to the same type and payload.
- Raw format: raw[17:16] = instruction_type (0 processing, 1 memory, 2 loop, 3 reserved); raw[15:0] = payload.
- Processing opcode is payload[15:13]; DIV = 3'd5, so raw DIV = 18'h0A000.
- Also validates loop nesting, tracks the memory write pointer and raises done or error for the host loader.

---
 rtl/control_unit_pkg.sv | 38 +++
 rtl/loop_depth_tracker.sv | 33 +++
 rtl/instruction_encoder.sv | 132 +++++++++++++
 tb/tb_instruction_encoder.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_unit_pkg.sv
// Shared instruction-format definitions for the control-unit encoder and decoder.
// Raw word = {instruction_type, payload}.
package control_unit_pkg;

   localparam int unsigned RAW_W     = 18;
   localparam int unsigned PAYLOAD_W = 16;
   localparam int unsigned LOOP_OP_W = 3;

   typedef enum logic [1:0] {
      PROC = 2'd0,
      MEM  = 2'd1,
      LOOP = 2'd2,
      RSVD = 2'd3
   } instr_type_t;

   // Loop opcodes live in payload[2:0] of a LOOP word
   localparam logic [LOOP_OP_W-1:0] LOOP_START = 3'd1;
   localparam logic [LOOP_OP_W-1:0] LOOP_END   = 3'd2;

   // Processing opcodes live in payload[15:13] of a PROC word
   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_MUL = 3'd4;
   localparam logic [2:0] OP_DIV = 3'd5;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_ILLEGAL  = 2'd1,
      ERR_OVERFLOW = 2'd2,
      ERR_NESTING  = 2'd3
   } err_code_t;

   typedef struct packed {
      instr_type_t            itype;
      logic [PAYLOAD_W-1:0]   payload;
   } raw_instr_t;

endpackage

// File: rtl/loop_depth_tracker.sv
// Up/down counter of open LOOP_START nesting, with look-ahead limit flags.
module loop_depth_tracker #(
   parameter int unsigned MAX_DEPTH = 4,
   parameter int unsigned DEPTH_W   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               inc,
   input  logic               dec,
   output logic [DEPTH_W-1:0] depth,
   output logic               would_overflow,
   output logic               would_underflow
);

   logic [DEPTH_W-1:0] r_depth;

   assign would_overflow  = (r_depth == DEPTH_W'(MAX_DEPTH));
   assign would_underflow = (r_depth == '0);
   assign depth           = r_depth;

   // Saturating guards make an illegal step a no-op rather than a wrap
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         r_depth <= '0;
      end else if (inc && !dec && !would_overflow) begin
         r_depth <= r_depth + DEPTH_W'(1);
      end else if (dec && !inc && !would_underflow) begin
         r_depth <= r_depth - DEPTH_W'(1);
      end
   end

endmodule

// File: rtl/instruction_encoder.sv
// Packs typed instruction fields into raw words and streams them into instruction
// memory, checking encoding, capacity and loop nesting along the way.
module instruction_encoder
   import control_unit_pkg::*;
#(
   parameter int unsigned ADDR_W         = 8,
   parameter int unsigned IMEM_DEPTH     = 256,
   parameter int unsigned MAX_LOOP_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [1:0]           in_type,
   input  logic [15:0]          in_payload,
   input  logic                 in_last,
   output logic                 imem_we,
   output logic [ADDR_W-1:0]    imem_addr,
   output logic [17:0]          imem_wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [1:0]           error_code,
   output logic [ADDR_W:0]      instr_count
);

   localparam int unsigned DEPTH_W = $clog2(MAX_LOOP_DEPTH + 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERROR} state_t;

   state_t              r_state;
   logic [ADDR_W:0]     r_ptr;
   logic                r_we;
   logic [ADDR_W-1:0]   r_addr;
   raw_instr_t          r_wdata;
   logic                r_done;
   logic                r_error;
   err_code_t           r_error_code;

   logic                w_accept;
   logic                w_is_loop;
   logic                w_loop_start;
   logic                w_loop_end;
   logic                w_illegal;
   logic                w_overflow;
   logic                w_nest_err;
   logic                w_commit;
   logic [DEPTH_W-1:0]  w_depth;
   logic [DEPTH_W-1:0]  w_post_depth;
   logic                w_would_ovf;
   logic                w_would_udf;
   err_code_t           w_err_code;

   assign in_ready    = (r_state == S_RUN) && !start;
   assign busy        = (r_state == S_RUN);
   assign imem_we     = r_we;
   assign imem_addr   = r_addr;
   assign imem_wdata  = r_wdata;
   assign done        = r_done;
   assign error       = r_error;
   assign error_code  = r_error_code;
   assign instr_count = r_ptr;

   assign w_accept     = in_valid && in_ready;
   assign w_is_loop    = (in_type == LOOP);
   assign w_loop_start = w_is_loop && (in_payload[2:0] == LOOP_START);
   assign w_loop_end   = w_is_loop && (in_payload[2:0] == LOOP_END);

   // Error classification of the presented word, highest priority first
   assign w_illegal    = (in_type == RSVD) || (w_is_loop && (in_payload[15:3] != '0));
   assign w_overflow   = (r_ptr == (ADDR_W+1)'(IMEM_DEPTH));
   assign w_post_depth = w_loop_start ? w_depth + DEPTH_W'(1) :
                         w_loop_end   ? w_depth - DEPTH_W'(1) : w_depth;
   assign w_nest_err   = (w_loop_end && w_would_udf) || (w_loop_start && w_would_ovf) ||
                         (in_last && (w_post_depth != '0));
   assign w_err_code   = w_illegal  ? ERR_ILLEGAL  :
                         w_overflow ? ERR_OVERFLOW :
                         w_nest_err ? ERR_NESTING  : ERR_NONE;
   assign w_commit     = w_accept && (w_err_code == ERR_NONE);

   loop_depth_tracker #(
      .MAX_DEPTH (MAX_LOOP_DEPTH),
      .DEPTH_W   (DEPTH_W)
   ) u_depth (
      .clk             (clk),
      .reset           (reset),
      .clear           (start),
      .inc             (w_commit && w_loop_start),
      .dec             (w_commit && w_loop_end),
      .depth           (w_depth),
      .would_overflow  (w_would_ovf),
      .would_underflow (w_would_udf)
   );

   // Control FSM; strobes default low so each write and done is a single-cycle pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_ptr        <= '0;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_error_code <= ERR_NONE;
      end else begin
         r_we   <= 1'b0;
         r_done <= 1'b0;
         if (start) begin
            r_state      <= S_RUN;
            r_ptr        <= '0;
            r_error      <= 1'b0;
            r_error_code <= ERR_NONE;
         end else if (w_accept) begin
            if (w_err_code != ERR_NONE) begin
               r_state      <= S_ERROR;
               r_error      <= 1'b1;
               r_error_code <= w_err_code;
            end else begin
               r_we    <= 1'b1;
               r_addr  <= r_ptr[ADDR_W-1:0];
               r_wdata <= '{itype: instr_type_t'(in_type), payload: in_payload};
               r_ptr   <= r_ptr + (ADDR_W+1)'(1);
               r_done  <= in_last;
               if (in_last) r_state <= S_DONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_instruction_encoder.sv
// Scoreboard bench: two encoders (default depth and a 4-word memory) share one
// stimulus stream; a program-level reference model predicts every write and status.
module tb_instruction_encoder;

   localparam int ST_IDLE = 0;
   localparam int ST_RUN  = 1;
   localparam int ST_DONE = 2;
   localparam int ST_ERR  = 3;
   localparam int MAX_NEST = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, start, in_valid, in_last;
   logic [1:0]  in_type;
   logic [15:0] in_payload;

   logic        a_ready, a_we, a_busy, a_done, a_err;
   logic [7:0]  a_addr;
   logic [17:0] a_wdata;
   logic [1:0]  a_code;
   logic [8:0]  a_cnt;
   logic        b_ready, b_we, b_busy, b_done, b_err;
   logic [7:0]  b_addr;
   logic [17:0] b_wdata;
   logic [1:0]  b_code;
   logic [8:0]  b_cnt;

   instruction_encoder dut_a (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(a_ready),
      .in_type(in_type), .in_payload(in_payload), .in_last(in_last),
      .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata), .busy(a_busy),
      .done(a_done), .error(a_err), .error_code(a_code), .instr_count(a_cnt));

   instruction_encoder #(.IMEM_DEPTH(4)) dut_b (
      .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(b_ready),
      .in_type(in_type), .in_payload(in_payload), .in_last(in_last),
      .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata), .busy(b_busy),
      .done(b_done), .error(b_err), .error_code(b_code), .instr_count(b_cnt));

   typedef struct {
      int          addr;
      logic [17:0] data;
      bit          last;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   m_st[2], m_ptr[2], m_dep[2], m_err[2], m_code[2];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: program-load rules applied per clock to both memory sizes
   task automatic model_step();
      for (int i = 0; i < 2; i++) begin
         int   lim;
         int   c;
         int   nd;
         int   op;
         exp_t e;
         lim = (i == 0) ? 256 : 4;
         if (reset) begin
            m_st[i] = ST_IDLE; m_ptr[i] = 0; m_dep[i] = 0; m_err[i] = 0; m_code[i] = 0;
         end else if (start) begin
            m_st[i] = ST_RUN; m_ptr[i] = 0; m_dep[i] = 0; m_err[i] = 0; m_code[i] = 0;
         end else if (m_st[i] == ST_RUN && in_valid) begin
            c  = 0;
            nd = m_dep[i];
            op = int'(in_payload[2:0]);
            if (in_type == 2'd3 || (in_type == 2'd2 && in_payload[15:3] != 13'd0)) c = 1;
            else if (m_ptr[i] == lim) c = 2;
            else begin
               if (in_type == 2'd2 && op == 1) begin
                  if (m_dep[i] == MAX_NEST) c = 3; else nd = m_dep[i] + 1;
               end
               if (in_type == 2'd2 && op == 2) begin
                  if (m_dep[i] == 0) c = 3; else nd = m_dep[i] - 1;
               end
               if (c == 0 && in_last && nd != 0) c = 3;
            end
            if (c != 0) begin
               m_st[i] = ST_ERR; m_err[i] = 1; m_code[i] = c;
            end else begin
               e.addr = m_ptr[i];
               e.data = {in_type, in_payload};
               e.last = in_last;
               if (i == 0) q0.push_back(e); else q1.push_back(e);
               m_ptr[i] = m_ptr[i] + 1;
               m_dep[i] = nd;
               if (in_last) m_st[i] = ST_DONE;
            end
         end
      end
   endtask

   task automatic check_dut(input int i, input string tag, input logic we, input logic [7:0] addr,
                            input logic [17:0] wd, input logic dn, input logic bsy,
                            input logic er, input logic [1:0] ec, input logic [8:0] cnt);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
      if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
      chk({tag, ".imem_we"}, 32'(we), 32'(have));
      if (have && we === 1'b1) begin
         chk({tag, ".imem_addr"}, 32'(addr), 32'(e.addr));
         chk({tag, ".imem_wdata"}, 32'(wd), 32'(e.data));
         chk({tag, ".done"}, 32'(dn), 32'(e.last));
      end else begin
         chk({tag, ".done_idle"}, 32'(dn), 32'd0);
      end
      chk({tag, ".busy"}, 32'(bsy), 32'(m_st[i] == ST_RUN));
      chk({tag, ".error"}, 32'(er), 32'(m_err[i]));
      chk({tag, ".error_code"}, 32'(ec), 32'(m_code[i]));
      chk({tag, ".instr_count"}, 32'(cnt), 32'(m_ptr[i]));
   endtask

   // Monitor: registered outputs sampled on the falling edge
   always @(negedge clk) begin
      if (mon_en) begin
         check_dut(0, "A", a_we, a_addr, a_wdata, a_done, a_busy, a_err, a_code, a_cnt);
         check_dut(1, "B", b_we, b_addr, b_wdata, b_done, b_busy, b_err, b_code, b_cnt);
      end
   end

   task automatic drive(input bit rs, input bit st, input bit v, input logic [1:0] t,
                        input logic [15:0] p, input bit l);
      reset = rs; start = st; in_valid = v; in_type = t; in_payload = p; in_last = l;
      #1;
      if (mon_en) begin
         chk("A.in_ready", 32'(a_ready), 32'(m_st[0] == ST_RUN && !st));
         chk("B.in_ready", 32'(b_ready), 32'(m_st[1] == ST_RUN && !st));
      end
      @(posedge clk);
      model_step();
      mon_en = 1'b1;
      @(negedge clk);
   endtask

   task automatic idle();                              drive(0, 0, 0, 2'd0, 16'h0, 0); endtask
   task automatic go();                                drive(0, 1, 0, 2'd0, 16'h0, 0); endtask
   task automatic word(input logic [1:0] t, input logic [15:0] p, input bit l);
      drive(0, 0, 1, t, p, l);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          rs, st, v, l;
      logic [1:0]  t;
      logic [15:0] p;
      int          r;

      drive(1, 0, 0, 2'd0, 16'h0, 0);
      drive(1, 0, 0, 2'd0, 16'h0, 0);
      chk("reset.imem_wdata", 32'(a_wdata), 32'd0);
      chk("reset.imem_addr", 32'(a_addr), 32'd0);
      chk("reset.in_ready", 32'(a_ready), 32'd0);
      idle();

      // Basic encode: DIV processing word as sole program
      go();
      word(2'd0, 16'hA000, 1);
      idle(); idle();

      // Mixed back-to-back stream with balanced loop
      go();
      word(2'd1, 16'h1234, 0);
      word(2'd0, 16'h2000, 0);
      word(2'd2, 16'h0001, 0);
      word(2'd2, 16'h0002, 1);
      idle();

      // Illegal encodings, then recovery
      go(); word(2'd3, 16'h0000, 0); idle(); go(); idle();
      go(); word(2'd2, 16'h0008, 0); idle();

      // Nesting limits
      go();
      for (int k = 0; k < 5; k++) word(2'd2, 16'h0001, 0);
      idle();
      go(); word(2'd2, 16'h0002, 0); idle();
      go(); word(2'd2, 16'h0001, 0); word(2'd0, 16'h0000, 1); idle();

      // Capacity: overflow, then exact fill
      go();
      for (int k = 0; k < 5; k++) word(2'd1, 16'(16'h0100 + k), 0);
      idle();
      go();
      for (int k = 0; k < 4; k++) word(2'd1, 16'(16'h0200 + k), k == 3);
      idle();

      // Start priority and in-flight writes across start/reset
      go();
      word(2'd0, 16'h4000, 0);
      drive(0, 1, 1, 2'd1, 16'hBEEF, 0);
      word(2'd1, 16'h5555, 0);
      word(2'd0, 16'h6000, 0);
      drive(1, 0, 0, 2'd0, 16'h0, 0);
      idle();

      // Randomized program loads
      for (int k = 0; k < 800; k++) begin
         r  = $urandom_range(0, 199);
         rs = (r == 0);
         st = ($urandom_range(0, 19) == 0) || (m_st[0] != ST_RUN && $urandom_range(0, 1) == 0);
         v  = ($urandom_range(0, 3) != 0);
         r  = $urandom_range(0, 15);
         t  = (r == 0) ? 2'd3 : (r < 6) ? 2'd2 : 2'(r[0]);
         if (t == 2'd2)
            p = {(($urandom_range(0, 15) == 0) ? 13'h1 : 13'h0), 3'($urandom_range(0, 3))};
         else
            p = 16'($urandom);
         l  = ($urandom_range(0, 7) == 0);
         drive(rs, st, v, t, p, l);
      end

      idle(); idle();
      chk("A.pending_writes", 32'(q0.size()), 32'd0);
      chk("B.pending_writes", 32'(q1.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
